camera_capture_ctrl: RTL and testbench
======================================

Name: camera_capture_ctrl

Overview:
Frame-capture scheduler between the camera pixel stream and the YOLO processing unit. It frames the per-pixel valid stream using a vsync pulse and writes each complete frame into one of two ping-pong frame buffers through a write port. It hands filled buffers to the consumer in order and drops whole frames when no buffer is free.

Parameters:
IMG_W, 416, pixels per line
IMG_H, 416, lines per frame
ADDR_W, 18, buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
CNT_W, 16, width of frame/drop/error counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  1-cycle pulse: arm capture
continuous  in  1  1 = keep capturing after each frame; 0 = single frame; sampled on start
stop  in  1  1-cycle pulse: abort and return to IDLE
vsync  in  1  1-cycle pulse marking start of frame; the pixel in the same cycle is not frame data
pix_data  in  24  RGB pixel from camera input stage
pix_valid  in  1  pixel qualifier
wr_en  out  1  buffer write strobe
wr_buf  out  1  target buffer index (0/1)
wr_addr  out  ADDR_W  pixel index within frame, row-major
wr_data  out  24  registered pix_data
frame_valid  out  1  a full buffer is available to the consumer
frame_buf  out  1  index of the oldest full buffer
frame_ack  in  1  1-cycle pulse: consumer releases frame_buf
busy  out  1  state != IDLE
frame_cnt  out  CNT_W  frames completed (wraps)
drop_cnt  out  CNT_W  frames dropped because no buffer was free (wraps)
err_cnt  out  CNT_W  short frames: vsync arrived before pixel count reached IMG_W*IMG_H (wraps)

Behaviour:
- Reset values: state IDLE; all outputs 0; both buffers free; write pointer 0; read pointer 0.
- State IDLE: ignores vsync and pixels. start -> WAIT_SOF.
- State WAIT_SOF: on vsync:
  - If the buffer at the write pointer is free: clear the pixel counter -> CAPTURE.
  - Otherwise: drop_cnt++ and remain in WAIT_SOF.
- State CAPTURE: each pix_valid causes, on the next cycle, wr_en=1, wr_data=pix_data, wr_addr=counter and wr_buf=write pointer; the counter then increments.
- Write latency is exactly one cycle. wr_en is 0 in every cycle not following an accepted pixel.
- Frame completion: the pixel with counter = IMG_W*IMG_H-1 completes the frame. In the same cycle as its wr_en:
  - the buffer is marked full;
  - frame_cnt++;
  - the write pointer toggles.
  - Next state is WAIT_SOF if continuous, else IDLE.
- Pixels arriving after completion and before the next vsync are ignored (no wr_en).
- Short frame: vsync in CAPTURE before completion means err_cnt++ and the counter resets to 0. Capture restarts in the same buffer, which stays free; no dropped-frame count.
- stop: in any state -> IDLE next cycle. A partial frame is abandoned and its buffer stays free. Full buffers and their frame_valid are unaffected. A pending registered write for the last accepted pixel still issues.
- start while busy: ignored. stop and start in the same cycle: stop wins.
- Consumer side:
  - frame_valid = buffer[read pointer] is full; frame_buf = read pointer.
  - frame_ack with frame_valid frees that buffer and toggles the read pointer; frame_valid updates the next cycle.
  - frame_ack without frame_valid is ignored.
- Ordering: frames are delivered in capture order. With both buffers full, the oldest is presented.
- Simultaneous frame completion and frame_ack on the other buffer: both take effect in the same cycle.
- Completing into the buffer being acked is impossible, because only free buffers are written.
- Counters wrap at 2^CNT_W with no saturation.
- Reset asserted mid-frame clears everything immediately (asynchronous) and discards buffer ownership.

Test Plan:
- IMG_W=4, IMG_H=2, continuous=0: start, vsync, 8 valid pixels 0x000001..0x000008 -> wr_en 8 times, wr_addr 0..7, wr_buf=0, one cycle after each pixel. Then frame_valid=1, frame_buf=0, frame_cnt=1, state IDLE, busy=0.
- continuous=1, no frame_ack, 3 frames sent -> frames 0 and 1 land in buf0/buf1; the third vsync gives drop_cnt=1 with no wr_en. frame_ack -> frame_buf switches to 1 and the next vsync captures into buf0.
- Short frame: vsync, 5 pixels, vsync, 8 pixels -> err_cnt=1. Second pass writes addr 0..7 in the same buffer; frame_cnt=1.
- stop after 3 pixels -> IDLE, busy=0 next cycle, buffer not full, frame_valid unchanged. Restart with start captures from addr 0.
- Gapped pix_valid (1 of every 3 cycles) plus extra pixels after completion -> exactly 8 writes with contiguous addresses; extras produce no wr_en.
- rst_n low mid-CAPTURE (asynchronous, between clock edges) -> all outputs 0 immediately; after release, a full frame works from buf0.

Source files
------------

// File: rtl/camera_capture_if.sv
// Camera-side pixel stream, frame-buffer write port and consumer handshake
// for the frame-capture scheduler. The controller is the master.
interface camera_capture_if #(
    parameter int ADDR_W = 18
) ();
    // Camera pixel stream
    logic              vsync;
    logic [23:0]       pix_data;
    logic              pix_valid;
    // Frame-buffer write port
    logic              wr_en;
    logic              wr_buf;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    // Consumer handshake
    logic              frame_valid;
    logic              frame_buf;
    logic              frame_ack;

    modport master (
        input  vsync, pix_data, pix_valid, frame_ack,
        output wr_en, wr_buf, wr_addr, wr_data, frame_valid, frame_buf
    );

    modport slave (
        output vsync, pix_data, pix_valid, frame_ack,
        input  wr_en, wr_buf, wr_addr, wr_data, frame_valid, frame_buf
    );
endinterface

// File: rtl/camera_capture_ctrl.sv
// Frame-capture scheduler: frames the camera pixel stream on vsync, writes
// each frame into one of two ping-pong buffers and hands full buffers to the
// consumer in capture order. Frames are dropped when no buffer is free.
module camera_capture_ctrl #(
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416,
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    camera_capture_if.master bus,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cont_q;
    logic [1:0]        buf_full_q, buf_full_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0] pix_cnt_q;
    logic              wr_en_q, wr_buf_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [23:0]       wr_data_q;
    logic [CNT_W-1:0]  frame_cnt_q, drop_cnt_q, err_cnt_q;

    // Per-cycle events decoded by the FSM
    logic accept, complete, sof, drop, short_frame, ack_ok;

    // Next-state and event decode; stop overrides everything else
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d     = state_q;
        accept      = 1'b0;
        complete    = 1'b0;
        sof         = 1'b0;
        drop        = 1'b0;
        short_frame = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (bus.vsync) begin
                    if (!buf_full_q[wr_ptr_q]) begin
                        sof     = 1'b1;
                        state_d = CAPTURE;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                // The pixel that shares a cycle with vsync is not frame data
                if (bus.vsync) begin
                    short_frame = 1'b1;
                end else if (bus.pix_valid) begin
                    accept = 1'b1;
                    if (pix_cnt_q == LAST_ADDR) begin
                        complete = 1'b1;
                        state_d  = cont_q ? WAIT_SOF : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d     = IDLE;
            accept      = 1'b0;
            complete    = 1'b0;
            sof         = 1'b0;
            drop        = 1'b0;
            short_frame = 1'b0;
        end
    end

    // Buffer ownership: completion fills the write buffer, an ack frees the read buffer
    always_comb begin
        ack_ok     = bus.frame_ack && buf_full_q[rd_ptr_q];
        buf_full_d = buf_full_q;
        if (complete) buf_full_d[wr_ptr_q] = 1'b1;
        if (ack_ok)   buf_full_d[rd_ptr_q] = 1'b0;
    end

    // State, pointers, pixel counter, registered write port and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cont_q      <= 1'b0;
            buf_full_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            pix_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_buf_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            wr_en_q    <= accept;
            if (state_q == IDLE && start && !stop) cont_q <= continuous;
            if (sof || short_frame) begin
                pix_cnt_q <= '0;
            end else if (accept) begin
                pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
            end
            if (accept) begin
                wr_buf_q  <= wr_ptr_q;
                wr_addr_q <= pix_cnt_q;
                wr_data_q <= bus.pix_data;
            end
            if (complete) begin
                wr_ptr_q    <= ~wr_ptr_q;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if (ack_ok)      rd_ptr_q   <= ~rd_ptr_q;
            if (drop)        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            if (short_frame) err_cnt_q  <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_buf      = wr_buf_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_valid = buf_full_q[rd_ptr_q];
    assign bus.frame_buf   = rd_ptr_q;
    assign busy            = (state_q != IDLE);
    assign frame_cnt       = frame_cnt_q;
    assign drop_cnt        = drop_cnt_q;
    assign err_cnt         = err_cnt_q;
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Self-checking bench for camera_capture_ctrl with a 4x2 frame: a hand-built
// vector table, directed corner-case sequences and randomized traffic, all
// compared every cycle against a queue-based reference model.
module tb_camera_capture_ctrl;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 18;
    localparam int CNT_W  = 16;
    localparam int NPIX   = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst_n;
    logic start, continuous, stop;
    logic busy;
    logic [CNT_W-1:0] frame_cnt, drop_cnt, err_cnt;

    camera_capture_if #(.ADDR_W(ADDR_W)) cam_if ();

    camera_capture_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .stop(stop), .bus(cam_if.master), .busy(busy),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks buffers as a queue of full buffer indices in capture order.
    int          m_mode;      // 0 idle, 1 waiting for vsync, 2 receiving pixels
    bit          m_cont;
    int          m_got;       // pixels received in the current frame
    int          m_full[$];   // oldest full buffer at the front
    bit          m_wbuf, m_rbuf;
    logic [15:0] m_frames, m_drops, m_errs;
    bit          m_wen, m_wb;
    int          m_waddr;
    logic [23:0] m_wdata;

    task automatic model_reset();
        m_mode = 0; m_cont = 0; m_got = 0; m_full.delete();
        m_wbuf = 0; m_rbuf = 0; m_frames = 0; m_drops = 0; m_errs = 0;
        m_wen = 0; m_wb = 0; m_waddr = 0; m_wdata = 0;
    endtask

    function automatic bit is_full(input bit b);
        foreach (m_full[i]) if (m_full[i] == int'(b)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit st, co, sp, vs, pv, input logic [23:0] pd, input bit ak);
        bit had_frame;
        had_frame = (m_full.size() > 0);
        m_wen = 0;
        if (sp) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_cont = co; end
        end else if (m_mode == 1) begin
            if (vs) begin
                if (is_full(m_wbuf)) m_drops++;
                else begin m_mode = 2; m_got = 0; end
            end
        end else begin
            if (vs) begin
                m_errs++; m_got = 0;
            end else if (pv) begin
                m_wen = 1; m_waddr = m_got; m_wb = m_wbuf; m_wdata = pd;
                m_got++;
                if (m_got == NPIX) begin
                    m_full.push_back(int'(m_wbuf));
                    m_frames++;
                    m_wbuf = ~m_wbuf;
                    m_mode = m_cont ? 1 : 0;
                end
            end
        end
        if (ak && had_frame) begin
            void'(m_full.pop_front());
            m_rbuf = ~m_rbuf;
        end
    endtask

    task automatic compare_model();
        check("wr_en", cam_if.wr_en, m_wen);
        if (m_wen) begin
            check("wr_addr", cam_if.wr_addr, m_waddr);
            check("wr_buf", cam_if.wr_buf, m_wb);
            check("wr_data", cam_if.wr_data, m_wdata);
        end
        check("frame_valid", cam_if.frame_valid, m_full.size() > 0);
        check("frame_buf", cam_if.frame_buf, m_rbuf);
        check("busy", busy, m_mode != 0);
        check("frame_cnt", frame_cnt, m_frames);
        check("drop_cnt", drop_cnt, m_drops);
        check("err_cnt", err_cnt, m_errs);
    endtask

    // One clock: drive inputs, advance model on the edge, sample 1 ns later
    task automatic step(input bit st, co, sp, vs, pv, input logic [23:0] pd, input bit ak);
        start = st; continuous = co; stop = sp;
        cam_if.vsync = vs; cam_if.pix_valid = pv; cam_if.pix_data = pd; cam_if.frame_ack = ak;
        @(posedge clk);
        model_step(st, co, sp, vs, pv, pd, ak);
        #1;
        compare_model();
        if (cam_if.wr_en) wr_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 24'h0, 0);
    endtask

    task automatic pixels(input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, base + 24'(i), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          st, co, sp, vs, pv, ak;
        logic [23:0] pd;
        bit          exp_wen;
        int          exp_addr;
        bit          exp_fv;
        bit          exp_busy;
        int          exp_fcnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Single 8-pixel frame, then consumer ack
        vecs[0] = '{st:1, co:0, sp:0, vs:0, pv:0, ak:0, pd:0, exp_wen:0, exp_addr:0, exp_fv:0, exp_busy:1, exp_fcnt:0};
        vecs[1] = '{st:0, co:0, sp:0, vs:1, pv:0, ak:0, pd:0, exp_wen:0, exp_addr:0, exp_fv:0, exp_busy:1, exp_fcnt:0};
        for (int i = 0; i < 8; i++)
            vecs[2+i] = '{st:0, co:0, sp:0, vs:0, pv:1, ak:0, pd:24'(i+1), exp_wen:1, exp_addr:i,
                          exp_fv:(i == 7), exp_busy:(i != 7), exp_fcnt:(i == 7) ? 1 : 0};
        vecs[10] = '{st:0, co:0, sp:0, vs:0, pv:0, ak:0, pd:0, exp_wen:0, exp_addr:0, exp_fv:1, exp_busy:0, exp_fcnt:1};
        vecs[11] = '{st:0, co:0, sp:0, vs:0, pv:0, ak:1, pd:0, exp_wen:0, exp_addr:0, exp_fv:0, exp_busy:0, exp_fcnt:1};

        rst_n = 1'b0;
        start = 0; continuous = 0; stop = 0;
        cam_if.vsync = 0; cam_if.pix_valid = 0; cam_if.pix_data = 0; cam_if.frame_ack = 0;
        model_reset();
        #12;
        check("reset_wr_en", cam_if.wr_en, 0);
        check("reset_frame_valid", cam_if.frame_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;

        // Table-driven single frame
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].st, vecs[i].co, vecs[i].sp, vecs[i].vs, vecs[i].pv, vecs[i].pd, vecs[i].ak);
            check($sformatf("vec%0d_wr_en", i), cam_if.wr_en, vecs[i].exp_wen);
            if (vecs[i].exp_wen) check($sformatf("vec%0d_wr_addr", i), cam_if.wr_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_frame_valid", i), cam_if.frame_valid, vecs[i].exp_fv);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_frame_cnt", i), frame_cnt, vecs[i].exp_fcnt);
        end

        // Continuous capture with no consumer: two frames fill both buffers,
        // third vsync is dropped; an ack frees the oldest and capture resumes.
        step(1, 1, 0, 0, 0, 24'h0, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        pixels(NPIX, 24'h100);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        pixels(NPIX, 24'h200);
        check("both_full_frame_buf", cam_if.frame_buf, 1);
        wr_seen = 0;
        step(0, 0, 0, 1, 1, 24'hBAD, 0);
        pixels(3, 24'hBAD);
        check("drop_cnt_after_full", drop_cnt, 1);
        check("drop_no_writes", wr_seen, 0);
        step(0, 0, 0, 0, 0, 24'h0, 1);
        check("ack_switches_frame_buf", cam_if.frame_buf, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        step(0, 0, 0, 0, 1, 24'h300, 0);
        check("resume_wr_buf", cam_if.wr_buf, 1);
        check("resume_wr_addr", cam_if.wr_addr, 0);
        pixels(NPIX - 1, 24'h301);
        check("cont_frame_cnt", frame_cnt, 4);
        step(0, 0, 1, 0, 0, 24'h0, 0);
        step(0, 0, 0, 0, 0, 24'h0, 1);
        step(0, 0, 0, 0, 0, 24'h0, 1);

        // Short frame: vsync, 5 pixels, vsync, full frame
        step(1, 0, 0, 0, 0, 24'h0, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        pixels(5, 24'h400);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        check("short_err_cnt", err_cnt, 1);
        pixels(NPIX, 24'h500);
        check("short_frame_cnt", frame_cnt, 5);
        check("short_frame_valid", cam_if.frame_valid, 1);

        // Stop after three pixels, then restart from address 0
        step(1, 0, 0, 0, 0, 24'h0, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        pixels(3, 24'h600);
        step(0, 0, 1, 0, 1, 24'h6FF, 0);
        check("stop_busy", busy, 0);
        check("stop_frame_valid_kept", cam_if.frame_valid, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 24'h0, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        pixels(NPIX, 24'h700);
        step(0, 0, 0, 0, 0, 24'h0, 1);
        step(0, 0, 0, 0, 0, 24'h0, 1);

        // Gapped pixels plus extras after completion
        step(1, 0, 0, 0, 0, 24'h0, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        wr_seen = 0;
        for (int i = 0; i < NPIX; i++) begin
            step(0, 0, 0, 0, 1, 24'h800 + 24'(i), 0);
            idle(2);
        end
        pixels(4, 24'h8F0);
        check("gapped_write_count", wr_seen, NPIX);
        step(0, 0, 0, 0, 0, 24'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 9) < 6, 24'($urandom), $urandom_range(0, 9) == 0);
        end
        step(0, 0, 1, 0, 0, 24'h0, 0);

        // Asynchronous reset in the middle of a frame
        step(1, 0, 0, 0, 0, 24'h0, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        pixels(4, 24'h900);
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", cam_if.wr_en, 0);
        check("arst_wr_addr", cam_if.wr_addr, 0);
        check("arst_frame_valid", cam_if.frame_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_counters", {frame_cnt, drop_cnt, err_cnt}, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 24'h0, 0);
        step(0, 0, 0, 1, 0, 24'h0, 0);
        step(0, 0, 0, 0, 1, 24'hA00, 0);
        check("post_reset_wr_buf", cam_if.wr_buf, 0);
        pixels(NPIX - 1, 24'hA01);
        check("post_reset_frame_cnt", frame_cnt, 1);
        check("post_reset_frame_buf", cam_if.frame_buf, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
